// File: rtl/cpeta_arb.sv
// Two-requester round-robin front end time-sharing one CPETA approximate adder.
// Optional exact-sum error monitor enabled by defining CPETA_ERRMON_EN.

module cpeta #(
  parameter int N = 16,
  parameter int K = 7
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] sum
);
  logic [K-1:0]   low;
  logic [N-K-1:0] hi;
  logic           stop;
  logic           cin;

  // Low part: XOR per bit, scanning down from the split. The first position where
  // both bits are set, and every bit below it, saturates to 1.
  always_comb begin
    low  = '0;
    stop = 1'b0;
    for (int i = K-1; i >= 0; i--) begin
      if (stop) begin
        low[i] = 1'b1;
      end else if (A[i] & B[i]) begin
        low[i] = 1'b1;
        stop   = 1'b1;
      end else begin
        low[i] = A[i] ^ B[i];
      end
    end
  end

  // Upper part is exact, with its carry-in predicted from the top low-part bit pair.
  assign cin = A[K-1] & B[K-1];
  assign hi  = A[N-1:K] + B[N-1:K] + {{(N-K-1){1'b0}}, cin};
  assign sum = {hi, low};
endmodule

module cpeta_arb #(
  parameter int N = 16,
  parameter int K = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [15:0]  err_cnt,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  typedef struct packed {
    logic         id;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } op_t;

  state_t       state, state_nxt;
  op_t          op_q;
  logic         ptr;
  logic         can_grant, gnt0, gnt1, gnt;
  logic [N-1:0] approx;

  // Readies are held low during reset so nothing is accepted by a held-off block.
  assign can_grant = rst_n & ((state == IDLE) | ((state == OUT) & rsp_ready));
  assign gnt0      = can_grant & req0_valid & (~req1_valid | ~ptr);
  assign gnt1      = can_grant & req1_valid & (~req0_valid |  ptr);
  assign gnt       = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign rsp_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     if (rsp_ready) state_nxt = gnt ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      op_q    <= '0;
      rsp_sum <= '0;
      rsp_id  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt) begin
        ptr  <= gnt0;
        op_q <= gnt0 ? op_t'{1'b0, req0_a, req0_b} : op_t'{1'b1, req1_a, req1_b};
      end
      if (state == CALC) begin
        rsp_sum <= approx;
        rsp_id  <= op_q.id;
      end
    end
  end

  cpeta #(.N(N), .K(K)) u_cpeta (
    .A   (op_q.a),
    .B   (op_q.b),
    .sum (approx)
  );

`ifdef CPETA_ERRMON_EN
  logic [N-1:0] exact;
  logic         mis;

  assign exact = op_q.a + op_q.b;
  assign mis   = (approx != exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else if (state == CALC) begin
      rsp_err <= mis;
      if (mis && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign rsp_err = 1'b0;
  assign err_cnt = '0;
`endif
endmodule
